coalescing_store_buffer: RTL and testbench

//  Parametrised N-entry FIFO store buffer between the C stage and the dcache port.

---
 rtl/brisc_pkg.sv | 32 +++
 rtl/coalescing_store_buffer_fwd_mux.sv | 61 ++++++
 rtl/coalescing_store_buffer.sv | 143 ++++++++++++++
 tb/tb_coalescing_store_buffer.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/brisc_pkg.sv
// Shared core types: access sizes, store-buffer entry layout and byte-enable helper.
// Pure declarations; no logic or timing.
// Used by the store buffer and its forwarding mux.
package brisc_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2
  } data_size_e;

  // One store-buffer slot at XLEN width: word address, data in byte lanes, byte enables.
  typedef struct packed {
    logic              valid;
    logic [XLEN-1:0]   addr;
    logic [XLEN-1:0]   data;
    logic [XLEN/8-1:0] be;
  } stb_entry_t;

  // Unshifted byte-enable pattern for an access size (lane 0 aligned).
  function automatic logic [3:0] size_to_be(input logic [1:0] size);
    case (size)
      SIZE_BYTE: size_to_be = 4'b0001;
      SIZE_HALF: size_to_be = 4'b0011;
      SIZE_WORD: size_to_be = 4'b1111;
      default:   size_to_be = 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/coalescing_store_buffer_fwd_mux.sv
// Load forwarding: per requested byte, pick the youngest matching entry covering it.
// Purely combinational, 0-cycle; sees only registered entries.
// No backpressure; hit/stall are advisory outputs to the C stage.
module stb_fwd_mux
  import brisc_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int BE_W   = DATA_W / 8,
  parameter int PTR_W  = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0]             ent_vld_i,
  input  logic [DEPTH-1:0][ADDR_W-1:0] ent_addr_i,
  input  logic [DEPTH-1:0][DATA_W-1:0] ent_data_i,
  input  logic [DEPTH-1:0][BE_W-1:0]   ent_be_i,
  input  logic [PTR_W-1:0]             head_i,
  input  logic                         load_valid_i,
  input  logic [ADDR_W-1:0]            load_addr_i,
  input  logic [1:0]                   load_size_i,
  output logic                         hit_o,
  output logic                         stall_o,
  output logic [DATA_W-1:0]            data_o
);

  localparam int OFF_W = $clog2(BE_W);

  logic [BE_W-1:0]   req_be;
  logic [BE_W-1:0]   cov;
  logic [DATA_W-1:0] lanes;
  logic [ADDR_W-1:0] lword;
  logic [PTR_W-1:0]  idx;

  // Walk entries oldest to youngest so a younger match overwrites an older byte.
  always_comb begin
    req_be = BE_W'(size_to_be(load_size_i)) << load_addr_i[OFF_W-1:0];
    lword  = {load_addr_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    cov    = '0;
    lanes  = '0;
    idx    = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head_i + PTR_W'(k);
      if (ent_vld_i[idx] && ent_addr_i[idx] == lword) begin
        for (int b = 0; b < BE_W; b++) begin
          if (ent_be_i[idx][b]) begin
            cov[b]          = 1'b1;
            lanes[8*b +: 8] = ent_data_i[idx][8*b +: 8];
          end
        end
      end
    end
    for (int b = 0; b < BE_W; b++) begin
      if (!req_be[b]) lanes[8*b +: 8] = 8'h00;
    end
  end

  assign hit_o   = load_valid_i && (req_be != '0) && ((req_be & ~cov) == '0);
  assign stall_o = load_valid_i && ((req_be & cov) != '0) && !hit_o;
  assign data_o  = hit_o ? (lanes >> {load_addr_i[OFF_W-1:0], 3'b000}) : '0;

endmodule

// File: rtl/coalescing_store_buffer.sv
// In-order store buffer with youngest-entry coalescing and byte-granular load forwarding.
// Store visible to drain/forwarding 1 cycle after acceptance; accept is combinational.
// Drain holds head stable while !drain_ready_in; stores refused when full unless merging.
module coalescing_store_buffer
  import brisc_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int COALESCE = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       store_valid_in,
  input  logic [ADDR_W-1:0]          store_addr_in,
  input  logic [DATA_W-1:0]          store_data_in,
  input  logic [1:0]                 store_size_in,
  output logic                       store_accept_out,
  input  logic                       load_valid_in,
  input  logic [ADDR_W-1:0]          load_addr_in,
  input  logic [1:0]                 load_size_in,
  output logic                       fwd_hit_out,
  output logic                       fwd_stall_out,
  output logic [DATA_W-1:0]          fwd_data_out,
  output logic                       drain_valid_out,
  output logic [ADDR_W-1:0]          drain_addr_out,
  output logic [DATA_W-1:0]          drain_data_out,
  output logic [DATA_W/8-1:0]        drain_be_out,
  input  logic                       drain_ready_in,
  output logic [$clog2(DEPTH):0]     count_out,
  output logic                       empty_out
);

  localparam int BE_W  = DATA_W / 8;
  localparam int OFF_W = $clog2(BE_W);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DEPTH-1:0]             vld_q,  vld_d;
  logic [DEPTH-1:0][ADDR_W-1:0] addr_q, addr_d;
  logic [DEPTH-1:0][DATA_W-1:0] data_q, data_d;
  logic [DEPTH-1:0][BE_W-1:0]   be_q,   be_d;
  logic [PTR_W-1:0]             head_q, head_d, tail_q, tail_d, tail_m1;
  logic [CNT_W-1:0]             count_q, count_d;

  logic [OFF_W-1:0]  st_off;
  logic [ADDR_W-1:0] st_word;
  logic [BE_W-1:0]   st_be;
  logic [DATA_W-1:0] st_lanes;
  logic              not_full, pop, merge_ok, do_merge, do_enq;

  assign st_off   = store_addr_in[OFF_W-1:0];
  assign st_word  = {store_addr_in[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign st_be    = BE_W'(size_to_be(store_size_in)) << st_off;
  assign st_lanes = store_data_in << {st_off, 3'b000};

  assign tail_m1  = tail_q - PTR_W'(1);
  assign not_full = count_q < CNT_W'(DEPTH);
  assign pop      = drain_valid_out && drain_ready_in;
  // A single entry being popped this cycle cannot also absorb a merge.
  assign merge_ok = (COALESCE != 0) && (count_q != '0) && (addr_q[tail_m1] == st_word)
                    && !((count_q == CNT_W'(1)) && pop);
  assign do_merge = store_valid_in && merge_ok;
  assign do_enq   = store_valid_in && !merge_ok && not_full;

  assign store_accept_out = merge_ok || not_full;
  assign drain_valid_out  = (count_q != '0);
  assign drain_addr_out   = addr_q[head_q];
  assign drain_data_out   = data_q[head_q];
  assign drain_be_out     = be_q[head_q];
  assign count_out        = count_q;
  assign empty_out        = (count_q == '0);

  // Next state: merge into youngest, enqueue at tail, retire head; indices never collide.
  always_comb begin
    vld_d   = vld_q;
    addr_d  = addr_q;
    data_d  = data_q;
    be_d    = be_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q + CNT_W'(do_enq) - CNT_W'(pop);
    if (do_merge) begin
      be_d[tail_m1] = be_q[tail_m1] | st_be;
      for (int b = 0; b < BE_W; b++) begin
        if (st_be[b]) data_d[tail_m1][8*b +: 8] = st_lanes[8*b +: 8];
      end
    end
    if (do_enq) begin
      vld_d[tail_q]  = 1'b1;
      addr_d[tail_q] = st_word;
      data_d[tail_q] = st_lanes;
      be_d[tail_q]   = st_be;
      tail_d         = tail_q + PTR_W'(1);
    end
    if (pop) begin
      vld_d[head_q] = 1'b0;
      head_d        = head_q + PTR_W'(1);
    end
  end

  // State registers; reset discards every entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      be_q    <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      vld_q   <= vld_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      be_q    <= be_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  stb_fwd_mux #(
    .DEPTH (DEPTH),
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .BE_W  (BE_W),
    .PTR_W (PTR_W)
  ) u_fwd (
    .ent_vld_i   (vld_q),
    .ent_addr_i  (addr_q),
    .ent_data_i  (data_q),
    .ent_be_i    (be_q),
    .head_i      (head_q),
    .load_valid_i(load_valid_in),
    .load_addr_i (load_addr_in),
    .load_size_i (load_size_in),
    .hit_o       (fwd_hit_out),
    .stall_o     (fwd_stall_out),
    .data_o      (fwd_data_out)
  );

endmodule

// File: tb/tb_coalescing_store_buffer.sv
// Directed bench: one coalescing instance (a_) and one non-coalescing instance (b_)
// share all inputs; each step checks hand-computed values with immediate assertions.
module tb_coalescing_store_buffer;
  import brisc_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        store_valid, load_valid, drain_ready;
  logic [31:0] store_addr, store_data, load_addr;
  logic [1:0]  store_size, load_size;

  logic        a_acc, a_hit, a_stall, a_dv, a_empty;
  logic [31:0] a_fdata, a_daddr, a_ddata;
  logic [3:0]  a_be;
  logic [2:0]  a_cnt;
  logic        b_acc, b_hit, b_stall, b_dv, b_empty;
  logic [31:0] b_fdata, b_daddr, b_ddata;
  logic [3:0]  b_be;
  logic [2:0]  b_cnt;

  int errors = 0;
  int checks = 0;
  logic acc_a, acc_b;

  always #5 clk = ~clk;

  coalescing_store_buffer #(.DEPTH(4), .DATA_W(32), .ADDR_W(32), .COALESCE(1)) dut_a (
    .clk(clk), .reset(reset),
    .store_valid_in(store_valid), .store_addr_in(store_addr), .store_data_in(store_data),
    .store_size_in(store_size), .store_accept_out(a_acc),
    .load_valid_in(load_valid), .load_addr_in(load_addr), .load_size_in(load_size),
    .fwd_hit_out(a_hit), .fwd_stall_out(a_stall), .fwd_data_out(a_fdata),
    .drain_valid_out(a_dv), .drain_addr_out(a_daddr), .drain_data_out(a_ddata),
    .drain_be_out(a_be), .drain_ready_in(drain_ready),
    .count_out(a_cnt), .empty_out(a_empty));

  coalescing_store_buffer #(.DEPTH(4), .DATA_W(32), .ADDR_W(32), .COALESCE(0)) dut_b (
    .clk(clk), .reset(reset),
    .store_valid_in(store_valid), .store_addr_in(store_addr), .store_data_in(store_data),
    .store_size_in(store_size), .store_accept_out(b_acc),
    .load_valid_in(load_valid), .load_addr_in(load_addr), .load_size_in(load_size),
    .fwd_hit_out(b_hit), .fwd_stall_out(b_stall), .fwd_data_out(b_fdata),
    .drain_valid_out(b_dv), .drain_addr_out(b_daddr), .drain_data_out(b_ddata),
    .drain_be_out(b_be), .drain_ready_in(drain_ready),
    .count_out(b_cnt), .empty_out(b_empty));

  // Misaligned accesses are illegal at the inputs.
  always @(negedge clk) begin
    if (!reset && store_valid)
      assert (!((store_size == SIZE_HALF && store_addr[0]) ||
                (store_size == SIZE_WORD && store_addr[1:0] != 2'b00)))
      else begin errors++; $error("FAIL misaligned_store addr=%h", store_addr); end
    if (!reset && load_valid)
      assert (!((load_size == SIZE_HALF && load_addr[0]) ||
                (load_size == SIZE_WORD && load_addr[1:0] != 2'b00)))
      else begin errors++; $error("FAIL misaligned_load addr=%h", load_addr); end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; store_valid = 1'b0; load_valid = 1'b0; drain_ready = 1'b0;
    tick(); tick();
    reset = 1'b0;
  endtask

  // Present a store for one cycle; acc_a/acc_b capture the combinational accept.
  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
    store_valid = 1'b1; store_addr = a; store_data = d; store_size = s;
    #2;
    acc_a = a_acc; acc_b = b_acc;
    tick();
    store_valid = 1'b0;
  endtask

  task automatic load(input logic [31:0] a, input logic [1:0] s);
    load_valid = 1'b1; load_addr = a; load_size = s;
    #1;
  endtask

  initial begin
    store_addr = '0; store_data = '0; store_size = SIZE_WORD;
    load_addr = '0; load_size = SIZE_WORD;
    do_reset();

    // Reset state
    chk("rst_count", 32'(a_cnt), 32'd0);
    chk("rst_empty", 32'(a_empty), 32'd1);
    chk("rst_drain_valid", 32'(a_dv), 32'd0);
    chk("rst_accept", 32'(a_acc), 32'd1);
    chk("rst_hit_stall", {30'd0, a_hit, a_stall}, 32'd0);
    chk("rst_fwd_data", a_fdata, 32'd0);

    // Fill to DEPTH, fifth store refused, head unchanged
    for (int i = 0; i < 4; i++) store(32'h100 + 32'(4*i), 32'h1000_0000 + 32'(i), SIZE_WORD);
    chk("fill_count", 32'(a_cnt), 32'd4);
    store(32'h110, 32'hDEAD_BEEF, SIZE_WORD);
    chk("full_accept", 32'(acc_a), 32'd0);
    chk("full_count", 32'(a_cnt), 32'd4);
    chk("full_drain_addr", a_daddr, 32'h100);
    chk("full_drain_be", 32'(a_be), 32'hF);
    chk("full_drain_data", a_ddata, 32'h1000_0000);

    // Full with pop in the same cycle: store still refused, space appears next cycle
    drain_ready = 1'b1;
    store(32'h400, 32'h4040_4040, SIZE_WORD);
    drain_ready = 1'b0;
    chk("pop_full_accept", 32'(acc_a), 32'd0);
    chk("pop_full_count", 32'(a_cnt), 32'd3);
    store(32'h400, 32'h4040_4040, SIZE_WORD);
    chk("after_pop_accept", 32'(acc_a), 32'd1);
    chk("after_pop_count", 32'(a_cnt), 32'd4);
    drain_ready = 1'b1;
    chk("order0", a_daddr, 32'h104); tick();
    chk("order1", a_daddr, 32'h108); tick();
    chk("order2", a_daddr, 32'h10C); tick();
    chk("order3", a_daddr, 32'h400);
    chk("order3_data", a_ddata, 32'h4040_4040); tick();
    chk("drained_empty", 32'(a_empty), 32'd1);
    drain_ready = 1'b0;

    // Byte coalescing into youngest entry
    do_reset();
    store(32'h201, 32'h0000_00AA, SIZE_BYTE);
    store(32'h202, 32'h0000_00BB, SIZE_BYTE);
    chk("merge_accept", 32'(acc_a), 32'd1);
    chk("merge_count", 32'(a_cnt), 32'd1);
    chk("merge_be", 32'(a_be), 32'b0110);
    chk("merge_data", a_ddata, 32'h00BB_AA00);
    chk("merge_addr", a_daddr, 32'h200);
    chk("nomerge_count", 32'(b_cnt), 32'd2);

    // No coalescing: youngest full-word store wins forwarding
    do_reset();
    store(32'h300, 32'h1122_3344, SIZE_WORD);
    store(32'h300, 32'h5566_7788, SIZE_WORD);
    load(32'h300, SIZE_WORD);
    chk("nc_count", 32'(b_cnt), 32'd2);
    chk("nc_hit", 32'(b_hit), 32'd1);
    chk("nc_stall", 32'(b_stall), 32'd0);
    chk("nc_data", b_fdata, 32'h5566_7788);
    chk("c_count", 32'(a_cnt), 32'd1);
    chk("c_data", a_fdata, 32'h5566_7788);
    load_valid = 1'b0; #1;
    chk("noload_hit", 32'(b_hit), 32'd0);

    // Partial overlap stalls; exact byte hits
    do_reset();
    store(32'h301, 32'h0000_005A, SIZE_BYTE);
    load(32'h300, SIZE_WORD);
    chk("partial_stall", 32'(b_stall), 32'd1);
    chk("partial_hit", 32'(b_hit), 32'd0);
    load(32'h301, SIZE_BYTE);
    chk("byte_hit", 32'(b_hit), 32'd1);
    chk("byte_data", b_fdata, 32'h0000_005A);
    load(32'h302, SIZE_HALF);
    chk("miss_hit_stall", {30'd0, b_hit, b_stall}, 32'd0);
    chk("miss_data", b_fdata, 32'd0);
    load_valid = 1'b0;

    // Same-cycle store is invisible to forwarding
    store_valid = 1'b1; store_addr = 32'h601; store_data = 32'h77; store_size = SIZE_BYTE;
    load(32'h601, SIZE_BYTE);
    chk("samecyc_hit", 32'(a_hit), 32'd0);
    tick();
    store_valid = 1'b0; #1;
    chk("nextcyc_hit", 32'(a_hit), 32'd1);
    chk("nextcyc_data", a_fdata, 32'h77);
    load_valid = 1'b0;

    // Single entry popping: same-word store enqueues instead of merging
    do_reset();
    store(32'h800, 32'hAAAA_0001, SIZE_WORD);
    drain_ready = 1'b1;
    store(32'h800, 32'hBBBB_0002, SIZE_WORD);
    drain_ready = 1'b0;
    chk("popmerge_count", 32'(a_cnt), 32'd1);
    chk("popmerge_data", a_ddata, 32'hBBBB_0002);

    // Stalled drain holds head stable, then reset discards everything
    do_reset();
    store(32'h700, 32'hCAFE_F00D, SIZE_WORD);
    store(32'h704, 32'h1234_5678, SIZE_WORD);
    for (int i = 0; i < 3; i++) begin
      chk("hold_valid", 32'(a_dv), 32'd1);
      chk("hold_addr", a_daddr, 32'h700);
      chk("hold_data", a_ddata, 32'hCAFE_F00D);
      tick();
    end
    reset = 1'b1; drain_ready = 1'b1;
    tick();
    reset = 1'b0; drain_ready = 1'b0; #1;
    chk("rst2_count", 32'(a_cnt), 32'd0);
    chk("rst2_empty", 32'(a_empty), 32'd1);
    chk("rst2_drain_valid", 32'(a_dv), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
